// File: rtl/db15_serial_reader.sv
// db15_serial_reader
// Serial front end for the DB15 user-port joystick adapter (74HC165-style
// parallel-load shift-register chain). Generates JOY_LOAD / JOY_CLK, samples
// JOY_DATA through a two-flop synchroniser and de-serialises one 24-bit frame
// holding both players. Decoded words are active-high and laid out like the
// DB9MD path: [0]R [1]L [2]D [3]U [4]A [5]B [6]C [7]D [8]E [9]F [10]Start
// [11]Mode, upper nibble zero. Both words update together on the valid pulse.

module db15_serial_reader #(
  parameter int CLK_DIV   = 32,   // clk cycles per tick (half JOY_CLK period), >= 4
  parameter int GAP_TICKS = 1000  // idle ticks between frames, >= 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        valid
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(GAP_TICKS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);
  localparam logic [4:0]       LAST_BIT = 5'd23;

  localparam logic [2:0] ST_GAP  = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_SLO  = 3'd2;
  localparam logic [2:0] ST_SHI  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Turn 12 raw active-low bits of one player into the active-high word.
  function automatic logic [15:0] decode_player(input logic [11:0] raw);
    decode_player = {4'b0000, ~raw};
  endfunction

  logic [DIV_W-1:0] div_r;
  logic             tick_s;
  logic             sync1_r;
  logic             sync2_r;

  logic [2:0]       state_r;
  logic [2:0]       state_s;
  logic [GAP_W-1:0] gap_cnt_r;
  logic [GAP_W-1:0] gap_cnt_s;
  logic             load_cnt_r;
  logic             load_cnt_s;
  logic [4:0]       bit_idx_r;
  logic [4:0]       bit_idx_s;
  logic [23:0]      frame_r;
  logic [23:0]      frame_s;

  logic             joy_clk_r;
  logic             joy_clk_s;
  logic             joy_load_r;
  logic             joy_load_s;
  logic [15:0]      joy1_r;
  logic [15:0]      joy1_s;
  logic [15:0]      joy2_r;
  logic [15:0]      joy2_s;
  logic             valid_r;
  logic             valid_s;

  // Free-running tick divider: wraps at CLK_DIV-1, tick marks the wrap cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_r <= {DIV_W{1'b0}};
    end else if (div_r == DIV_LAST) begin
      div_r <= {DIV_W{1'b0}};
    end else begin
      div_r <= div_r + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  assign tick_s = (div_r == DIV_LAST);

  // Two-flop synchroniser for the asynchronous serial data; idles high
  // so an absent adapter reads as "no buttons pressed".
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= JOY_DATA;
      sync2_r <= sync1_r;
    end
  end

  // Frame sequencer: gap, load pulse, 24 sample/shift half-periods, publish.
  always_comb begin
    state_s    = state_r;
    gap_cnt_s  = gap_cnt_r;
    load_cnt_s = load_cnt_r;
    bit_idx_s  = bit_idx_r;
    frame_s    = frame_r;
    joy_clk_s  = joy_clk_r;
    joy_load_s = joy_load_r;
    joy1_s     = joy1_r;
    joy2_s     = joy2_r;
    valid_s    = 1'b0;

    case (state_r)
      ST_GAP: begin
        joy_clk_s  = 1'b0;
        joy_load_s = 1'b1;
        if (tick_s) begin
          if (gap_cnt_r == GAP_LAST) begin
            gap_cnt_s  = {GAP_W{1'b0}};
            load_cnt_s = 1'b0;
            joy_load_s = 1'b0;
            state_s    = ST_LOAD;
          end else begin
            gap_cnt_s = gap_cnt_r + {{(GAP_W-1){1'b0}}, 1'b1};
          end
        end else begin
          gap_cnt_s = gap_cnt_r;
        end
      end

      ST_LOAD: begin
        // JOY_LOAD stays low for two full ticks; the clock stays parked low.
        joy_clk_s = 1'b0;
        if (tick_s) begin
          if (load_cnt_r) begin
            joy_load_s = 1'b1;
            bit_idx_s  = 5'd0;
            state_s    = ST_SLO;
          end else begin
            load_cnt_s = 1'b1;
          end
        end else begin
          load_cnt_s = load_cnt_r;
        end
      end

      ST_SLO: begin
        // Data for the current bit has been stable for a whole tick here.
        if (tick_s) begin
          frame_s[bit_idx_r] = sync2_r;
          if (bit_idx_r == LAST_BIT) begin
            state_s = ST_DONE;
          end else begin
            joy_clk_s = 1'b1;
            state_s   = ST_SHI;
          end
        end else begin
          joy_clk_s = 1'b0;
        end
      end

      ST_SHI: begin
        if (tick_s) begin
          joy_clk_s = 1'b0;
          bit_idx_s = bit_idx_r + 5'd1;
          state_s   = ST_SLO;
        end else begin
          joy_clk_s = 1'b1;
        end
      end

      ST_DONE: begin
        // Both words are replaced in the same cycle, so no torn frame is seen.
        joy1_s     = decode_player(frame_r[11:0]);
        joy2_s     = decode_player(frame_r[23:12]);
        valid_s    = 1'b1;
        gap_cnt_s  = {GAP_W{1'b0}};
        joy_clk_s  = 1'b0;
        joy_load_s = 1'b1;
        state_s    = ST_GAP;
      end

      default: begin
        gap_cnt_s  = {GAP_W{1'b0}};
        joy_clk_s  = 1'b0;
        joy_load_s = 1'b1;
        state_s    = ST_GAP;
      end
    endcase
  end

  // Sequencer and output registers; reset abandons any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_GAP;
      gap_cnt_r  <= {GAP_W{1'b0}};
      load_cnt_r <= 1'b0;
      bit_idx_r  <= 5'd0;
      frame_r    <= 24'hFF_FFFF;
      joy_clk_r  <= 1'b0;
      joy_load_r <= 1'b1;
      joy1_r     <= 16'h0000;
      joy2_r     <= 16'h0000;
      valid_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      gap_cnt_r  <= gap_cnt_s;
      load_cnt_r <= load_cnt_s;
      bit_idx_r  <= bit_idx_s;
      frame_r    <= frame_s;
      joy_clk_r  <= joy_clk_s;
      joy_load_r <= joy_load_s;
      joy1_r     <= joy1_s;
      joy2_r     <= joy2_s;
      valid_r    <= valid_s;
    end
  end

  assign JOY_CLK   = joy_clk_r;
  assign JOY_LOAD  = joy_load_r;
  assign joystick1 = joy1_r;
  assign joystick2 = joy2_r;
  assign valid     = valid_r;

endmodule
